dec3to8_seq: RTL and testbench

Registered 3-to-8 line decoder with a valid/ready input handshake and a programmable output hold time. It is the return path for the 8-to-3 priority encoder: it turns a 3-bit code back into a one-hot line vector and holds that vector for a fixed number of cycles. The outputs are clean, glitch-free and register-driven, so they can directly drive one-hot select lines or LED/segment enables downstream.

---
 rtl/dec3to8_seq.sv | 71 +++++++
 tb/tb_dec3to8_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dec3to8_seq.sv
// Registered 3-to-8 decoder with valid/ready intake and a fixed per-code hold time.
// Y/valid/busy come straight from flops so they can drive one-hot selects directly.
module dec3to8_seq #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [2:0] Din,
    input  logic       valid_in,
    output logic       ready,
    output logic [7:0] Y,
    output logic       valid,
    output logic       busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] y_nxt;
    logic       accept;

    // State register; valid/busy are registered views of the next Y/state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            Y     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Y     <= y_nxt;
            valid <= (y_nxt != 8'd0);
            busy  <= (state_nxt == HOLD);
        end
    end

    // EN low wins over accept; the last HOLD cycle (cnt==0) may take a new code
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = Y;
        if (!EN) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            y_nxt     = '0;
        end else if (accept) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_LOAD;
            y_nxt     = 8'd1 << Din;
        end else if (state == HOLD) begin
            if (cnt != 8'd0) begin
                cnt_nxt = cnt - 8'd1;
            end else begin
                state_nxt = IDLE;
                y_nxt     = '0;
            end
        end
    end

    always_comb begin
        ready  = rst_n & EN & ((state == IDLE) | (cnt == 8'd0));
        accept = valid_in & ready;
    end

endmodule

// File: tb/tb_dec3to8_seq.sv
// Scoreboard bench for dec3to8_seq: per-cycle stimulus tables, expected Y queued at drive
// time and popped after the edge. A HOLD_CYCLES=1 instance covers the streaming case.
module tb_dec3to8_seq;

    logic       clk = 1'b0;
    logic       rst_n, en, valid_in;
    logic [2:0] din;
    logic       ready4, valid4, busy4;
    logic [7:0] y4;
    logic       ready1, valid1, busy1;
    logic [7:0] y1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       vin;
        logic [2:0] din;
        logic       rdy;
        logic [7:0] y;
    } step_t;

    always #5 clk = ~clk;

    dec3to8_seq #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .EN(en), .Din(din), .valid_in(valid_in),
        .ready(ready4), .Y(y4), .valid(valid4), .busy(busy4)
    );

    dec3to8_seq #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .EN(en), .Din(din), .valid_in(valid_in),
        .ready(ready1), .Y(y1), .valid(valid1), .busy(busy1)
    );

    function automatic step_t mk(input logic r, input logic e, input logic v,
                                 input logic [2:0] d, input logic rdy, input logic [7:0] y);
        step_t s;
        s.rst_n = r; s.en = e; s.vin = v; s.din = d; s.rdy = rdy; s.y = y;
        return s;
    endfunction

    task automatic test_reset();
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            rst_n = 1'b0; en = 1'b1; valid_in = 1'b1; din = 3'd3;
            #1;
            checks++;
            if (ready4 !== 1'b0) begin errors++; $display("FAIL reset_ready cyc=%0d got=%b exp=0", i, ready4); end
            exp_q.push_back(8'h00);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (y4 !== e || valid4 !== 1'b0 || busy4 !== 1'b0) begin
                errors++; $display("FAIL reset_outputs cyc=%0d got Y=%h v=%b b=%b exp Y=%h v=0 b=0", i, y4, valid4, busy4, e);
            end
        end
    endtask

    task automatic test_sweep();
        step_t s[$];
        logic [7:0] e;
        for (int c = 0; c <= 32; c++)
            s.push_back(mk(1'b1, 1'b1, c < 32, 3'((c + 3) / 4), (c % 4) == 0,
                           (c < 32) ? (8'd1 << (c / 4)) : 8'd0));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; en = s[i].en; valid_in = s[i].vin; din = s[i].din;
            #1;
            checks++;
            if (ready4 !== s[i].rdy) begin errors++; $display("FAIL sweep_ready cyc=%0d got=%b exp=%b", i, ready4, s[i].rdy); end
            exp_q.push_back(s[i].y);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (y4 !== e || valid4 !== (e != 0) || busy4 !== (e != 0)) begin
                errors++; $display("FAIL sweep_y cyc=%0d got Y=%h v=%b b=%b exp Y=%h", i, y4, valid4, busy4, e);
            end
        end
    endtask

    task automatic test_isolated();
        step_t s[$];
        logic [7:0] e;
        s.push_back(mk(1, 1, 1, 3'd5, 1, 8'h20));
        s.push_back(mk(1, 1, 0, 3'd0, 0, 8'h20));
        s.push_back(mk(1, 1, 0, 3'd0, 0, 8'h20));
        s.push_back(mk(1, 1, 0, 3'd0, 0, 8'h20));
        s.push_back(mk(1, 1, 0, 3'd0, 1, 8'h00));
        s.push_back(mk(1, 1, 0, 3'd0, 1, 8'h00));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; en = s[i].en; valid_in = s[i].vin; din = s[i].din;
            #1;
            checks++;
            if (ready4 !== s[i].rdy) begin errors++; $display("FAIL isolated_ready cyc=%0d got=%b exp=%b", i, ready4, s[i].rdy); end
            exp_q.push_back(s[i].y);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (y4 !== e || valid4 !== (e != 0) || busy4 !== (e != 0)) begin
                errors++; $display("FAIL isolated_y cyc=%0d got Y=%h v=%b b=%b exp Y=%h", i, y4, valid4, busy4, e);
            end
        end
    endtask

    task automatic test_enable_abort();
        step_t s[$];
        logic [7:0] e;
        s.push_back(mk(1, 1, 1, 3'd3, 1, 8'h08));
        s.push_back(mk(1, 1, 0, 3'd0, 0, 8'h08));
        s.push_back(mk(1, 0, 0, 3'd0, 0, 8'h00));
        s.push_back(mk(1, 0, 1, 3'd3, 0, 8'h00));
        s.push_back(mk(1, 0, 1, 3'd6, 0, 8'h00));
        s.push_back(mk(1, 1, 0, 3'd0, 1, 8'h00));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; en = s[i].en; valid_in = s[i].vin; din = s[i].din;
            #1;
            checks++;
            if (ready4 !== s[i].rdy) begin errors++; $display("FAIL abort_ready cyc=%0d got=%b exp=%b", i, ready4, s[i].rdy); end
            exp_q.push_back(s[i].y);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (y4 !== e || valid4 !== (e != 0) || busy4 !== (e != 0)) begin
                errors++; $display("FAIL abort_y cyc=%0d got Y=%h v=%b b=%b exp Y=%h", i, y4, valid4, busy4, e);
            end
        end
    endtask

    task automatic test_stalled();
        step_t s[$];
        logic [7:0] e;
        s.push_back(mk(1, 1, 1, 3'd1, 1, 8'h02));
        for (int k = 0; k < 3; k++) s.push_back(mk(1, 1, 1, 3'd6, 0, 8'h02));
        s.push_back(mk(1, 1, 1, 3'd6, 1, 8'h40));
        for (int k = 0; k < 3; k++) s.push_back(mk(1, 1, 0, 3'd0, 0, 8'h40));
        s.push_back(mk(1, 1, 0, 3'd0, 1, 8'h00));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; en = s[i].en; valid_in = s[i].vin; din = s[i].din;
            #1;
            checks++;
            if (ready4 !== s[i].rdy) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", i, ready4, s[i].rdy); end
            exp_q.push_back(s[i].y);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (y4 !== e || valid4 !== (e != 0) || busy4 !== (e != 0)) begin
                errors++; $display("FAIL stall_y cyc=%0d got Y=%h v=%b b=%b exp Y=%h", i, y4, valid4, busy4, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        step_t s[$];
        logic [7:0] e;
        s.push_back(mk(1, 1, 1, 3'd7, 1, 8'h80));
        s.push_back(mk(1, 1, 0, 3'd0, 0, 8'h80));
        s.push_back(mk(0, 1, 1, 3'd0, 0, 8'h00));
        s.push_back(mk(1, 1, 1, 3'd0, 1, 8'h01));
        for (int k = 0; k < 3; k++) s.push_back(mk(1, 1, 0, 3'd0, 0, 8'h01));
        s.push_back(mk(1, 1, 0, 3'd0, 1, 8'h00));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; en = s[i].en; valid_in = s[i].vin; din = s[i].din;
            #1;
            checks++;
            if (ready4 !== s[i].rdy) begin errors++; $display("FAIL rsthold_ready cyc=%0d got=%b exp=%b", i, ready4, s[i].rdy); end
            exp_q.push_back(s[i].y);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (y4 !== e || valid4 !== (e != 0) || busy4 !== (e != 0)) begin
                errors++; $display("FAIL rsthold_y cyc=%0d got Y=%h v=%b b=%b exp Y=%h", i, y4, valid4, busy4, e);
            end
        end
    endtask

    task automatic test_back_to_back_hold1();
        step_t s[$];
        logic [7:0] e;
        s.push_back(mk(1, 1, 1, 3'd7, 1, 8'h80));
        s.push_back(mk(1, 1, 1, 3'd2, 1, 8'h04));
        s.push_back(mk(1, 1, 1, 3'd4, 1, 8'h10));
        s.push_back(mk(1, 1, 0, 3'd0, 1, 8'h00));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; en = s[i].en; valid_in = s[i].vin; din = s[i].din;
            #1;
            checks++;
            if (ready1 !== s[i].rdy) begin errors++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", i, ready1, s[i].rdy); end
            exp_q.push_back(s[i].y);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (y1 !== e || valid1 !== (e != 0) || busy1 !== (e != 0)) begin
                errors++; $display("FAIL stream_y cyc=%0d got Y=%h v=%b b=%b exp Y=%h", i, y1, valid1, busy1, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; valid_in = 1'b0; din = 3'd0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_isolated();
        test_enable_abort();
        test_stalled();
        test_reset_mid_hold();
        test_back_to_back_hold1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
